// File: rtl/jam_pkg.sv
// Shared types and width helpers for the exhaustive job-assignment search engine.
package jam_pkg;

  typedef enum logic [1:0] {IDLE, ACC, CMP, DONE} jam_state_t;

  function automatic int jam_idx_w(input int n);
    return $clog2(n);
  endfunction

  // N entries of COST_W bits each never overflow this width.
  function automatic int jam_sum_w(input int n, input int cost_w);
    return cost_w + $clog2(n);
  endfunction

endpackage

// File: rtl/jam_next_perm.sv
// Combinational lexicographic successor of a packed permutation; flags the final (descending) one.
module jam_next_perm #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N*IDX_W-1:0] perm,
  output logic [N*IDX_W-1:0] next_perm,
  output logic               last
);

  logic [IDX_W-1:0] p [N];
  logic [IDX_W-1:0] s [N];
  logic [IDX_W-1:0] pv;
  logic [IDX_W-1:0] kv;
  int               piv;
  int               k;

  // Index arithmetic stays on loop constants so no array is addressed by a runtime value.
  always_comb begin
    for (int i = 0; i < N; i++) p[i] = perm[i*IDX_W +: IDX_W];
    piv  = 0;
    pv   = p[0];
    last = 1'b1;
    for (int i = 0; i < N - 1; i++) begin
      if (p[i] < p[i+1]) begin
        piv  = i;
        pv   = p[i];
        last = 1'b0;
      end
    end
    k  = piv;
    kv = pv;
    for (int i = 0; i < N; i++) begin
      if (i > piv && p[i] > pv) begin
        k  = i;
        kv = p[i];
      end
    end
    for (int i = 0; i < N; i++) begin
      if (i == piv)    s[i] = kv;
      else if (i == k) s[i] = pv;
      else             s[i] = p[i];
    end
    next_perm = '0;
    for (int i = 0; i < N; i++) begin
      if (i <= piv) next_perm[i*IDX_W +: IDX_W] = s[i];
      for (int m = 0; m < N; m++) begin
        if (i > piv && m == N + piv - i) next_perm[i*IDX_W +: IDX_W] = s[m];
      end
    end
  end

endmodule

// File: rtl/jam_perm_engine.sv
// Exhaustive N-worker/N-job assignment search: walks every permutation, summing table
// costs one entry per cycle, and keeps the minimum, its match count and the first optimum.
module jam_perm_engine
  import jam_pkg::*;
#(
  parameter int N          = 8,
  parameter int COST_W     = 7,
  parameter int CNT_W      = 16,
  parameter bit AUTO_START = 1'b1,
  localparam int IDX_W     = jam_idx_w(N),
  localparam int SUM_W     = jam_sum_w(N, COST_W)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Start,
  output logic [IDX_W-1:0]     W,
  output logic [IDX_W-1:0]     J,
  input  logic [COST_W-1:0]    Cost,
  output logic [SUM_W-1:0]     MinCost,
  output logic [CNT_W-1:0]     MatchCount,
  output logic [N*IDX_W-1:0]   BestAssign,
  output logic                 Valid
);

  function automatic logic [N*IDX_W-1:0] identity_perm();
    logic [N*IDX_W-1:0] r;
    r = '0;
    for (int w = 0; w < N; w++) r[w*IDX_W +: IDX_W] = IDX_W'(w);
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  localparam logic [N*IDX_W-1:0] IDENT    = identity_perm();
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N - 1);

  jam_state_t         state;
  logic [N*IDX_W-1:0] perm;
  logic [N*IDX_W-1:0] next_perm;
  logic               last;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_inc;
  logic [IDX_W-1:0]   j_q;
  logic [SUM_W-1:0]   sum;

  jam_next_perm #(.N(N), .IDX_W(IDX_W)) u_next (
    .perm      (perm),
    .next_perm (next_perm),
    .last      (last)
  );

  assign idx_inc = idx + IDX_W'(1);
  assign W       = idx;
  assign J       = j_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= AUTO_START ? ACC : IDLE;
      perm       <= IDENT;
      idx        <= '0;
      j_q        <= '0;
      sum        <= '0;
      MinCost    <= '1;
      MatchCount <= '0;
      BestAssign <= '0;
      Valid      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            state      <= ACC;
            perm       <= IDENT;
            idx        <= '0;
            j_q        <= IDENT[IDX_W-1:0];
            sum        <= '0;
            MinCost    <= '1;
            MatchCount <= '0;
            Valid      <= 1'b0;
          end
        end
        ACC: begin
          sum <= sum + SUM_W'(Cost);
          if (idx == LAST_IDX) begin
            state <= CMP;
          end else begin
            idx <= idx_inc;
            j_q <= perm[idx_inc*IDX_W +: IDX_W];
          end
        end
        CMP: begin
          // Strict less-than keeps the lexicographically earliest optimum on ties.
          if (sum < MinCost) begin
            MinCost    <= sum;
            MatchCount <= CNT_W'(1);
            BestAssign <= perm;
          end else if (sum == MinCost) begin
            MatchCount <= sat_inc(MatchCount);
          end
          if (last) begin
            state <= DONE;
            Valid <= 1'b1;
          end else begin
            state <= ACC;
            perm  <= next_perm;
            idx   <= '0;
            j_q   <= next_perm[IDX_W-1:0];
            sum   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jam_perm_engine.sv
// Bench for jam_perm_engine: an N=3 auto-start instance and an N=4 Start-driven instance with a 4-bit counter.
`timescale 1ns/1ps
module tb_jam_perm_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0][6:0] tab;
    logic [8:0]       min;
    logic [15:0]      cnt;
    logic [7:0]       best;
  } vec_t;

  int total = 0;
  int bad   = 0;
  vec_t exp_q[$];

  // ---------------- instance A: N=3, auto start ----------------
  logic       rst_a, start_a;
  logic [1:0] w_a, j_a;
  logic [6:0] cost_a;
  logic [8:0] min_a;
  logic [15:0] cnt_a;
  logic [5:0] best_a;
  logic       valid_a;
  logic [6:0] tab_a [4][4];
  assign cost_a = tab_a[w_a][j_a];

  jam_perm_engine #(.N(3), .COST_W(7), .CNT_W(16), .AUTO_START(1'b1)) dut_a (
    .CLK(clk), .RST(rst_a), .Start(start_a), .W(w_a), .J(j_a), .Cost(cost_a),
    .MinCost(min_a), .MatchCount(cnt_a), .BestAssign(best_a), .Valid(valid_a)
  );

  // ---------------- instance B: N=4, Start driven, 4-bit count ----------------
  logic       rst_b, start_b;
  logic [1:0] w_b, j_b;
  logic [6:0] cost_b;
  logic [8:0] min_b;
  logic [3:0] cnt_b;
  logic [7:0] best_b;
  logic       valid_b;
  logic [6:0] tab_b [4][4];
  assign cost_b = tab_b[w_b][j_b];

  jam_perm_engine #(.N(4), .COST_W(7), .CNT_W(4), .AUTO_START(1'b0)) dut_b (
    .CLK(clk), .RST(rst_b), .Start(start_b), .W(w_b), .J(j_b), .Cost(cost_b),
    .MinCost(min_b), .MatchCount(cnt_b), .BestAssign(best_b), .Valid(valid_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0][6:0] flat(input int v);
    logic [15:0][6:0] t;
    for (int i = 0; i < 16; i++) t[i] = 7'(v);
    return t;
  endfunction

  function automatic logic [15:0][6:0] diag(input int on, input int off);
    logic [15:0][6:0] t;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r*4+c] = (r == c) ? 7'(on) : 7'(off);
    return t;
  endfunction

  // Brute-force reference for N=4: nested loops visit assignments in lexicographic order.
  function automatic vec_t model4(input logic [15:0][6:0] t);
    vec_t v;
    int   bs, cnt, s;
    bs = 1 << 30;
    cnt = 0;
    v = '0;
    v.tab = t;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 4; c++)
          for (int d = 0; d < 4; d++) begin
            if (a != b && a != c && a != d && b != c && b != d && c != d) begin
              s = int'(t[a]) + int'(t[4+b]) + int'(t[8+c]) + int'(t[12+d]);
              if (s < bs) begin
                bs = s;
                cnt = 1;
                v.best = {2'(d), 2'(c), 2'(b), 2'(a)};
              end else if (s == bs) begin
                cnt++;
              end
            end
          end
    v.min = 9'(bs);
    v.cnt = (cnt > 15) ? 16'd15 : 16'(cnt);
    return v;
  endfunction

  task automatic load_a(input vec_t v);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) tab_a[r][c] = v.tab[r*4+c];
  endtask

  task automatic load_b(input vec_t v);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) tab_b[r][c] = v.tab[r*4+c];
  endtask

  task automatic reset_vals_a(input string tag);
    check({tag, "_W"}, 32'(w_a), 0);
    check({tag, "_J"}, 32'(j_a), 0);
    check({tag, "_min"}, 32'(min_a), 511);
    check({tag, "_cnt"}, 32'(cnt_a), 0);
    check({tag, "_best"}, 32'(best_a), 0);
    check({tag, "_valid"}, 32'(valid_a), 0);
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic pulse_start_b();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
  endtask

  // Waits for Valid, pops the scoreboard and compares; 'already' = edges elapsed since search start.
  task automatic finish_a(input string tag, input int already);
    vec_t e;
    int   cyc;
    cyc = 0;
    while (!valid_a && cyc < 80) begin tick(); cyc++; end
    check({tag, "_valid"}, 32'(valid_a), 1);
    check({tag, "_cycles"}, 32'(cyc + already), 24);
    e = exp_q.pop_front();
    check({tag, "_min"}, 32'(min_a), 32'(e.min));
    check({tag, "_cnt"}, 32'(cnt_a), 32'(e.cnt));
    check({tag, "_best"}, 32'(best_a), 32'(e.best[5:0]));
  endtask

  task automatic finish_b(input string tag);
    vec_t e;
    int   cyc;
    cyc = 0;
    while (!valid_b && cyc < 300) begin tick(); cyc++; end
    check({tag, "_valid"}, 32'(valid_b), 1);
    check({tag, "_cycles"}, 32'(cyc), 120);
    e = exp_q.pop_front();
    check({tag, "_min"}, 32'(min_b), 32'(e.min));
    check({tag, "_cnt"}, 32'(cnt_b), 32'(e.cnt));
    check({tag, "_best"}, 32'(best_b), 32'(e.best));
  endtask

  vec_t vec_a [5];
  vec_t vec_b [5];

  initial begin
    rst_a = 1'b1; start_a = 1'b0;
    rst_b = 1'b1; start_b = 1'b0;

    // N=3 vectors: best fields are 2 bits per worker, worker0 in the low bits.
    vec_a[0] = '0;
    vec_a[0].tab[0] = 7'd5; vec_a[0].tab[1] = 7'd1; vec_a[0].tab[2]  = 7'd9;
    vec_a[0].tab[4] = 7'd2; vec_a[0].tab[5] = 7'd8; vec_a[0].tab[6]  = 7'd4;
    vec_a[0].tab[8] = 7'd7; vec_a[0].tab[9] = 7'd3; vec_a[0].tab[10] = 7'd6;
    vec_a[0].min = 9'd9;   vec_a[0].cnt = 16'd1; vec_a[0].best = 8'h21;
    vec_a[1] = '{tab: flat(1),      min: 9'd3,   cnt: 16'd6, best: 8'h24};
    vec_a[2] = '{tab: diag(0, 10),  min: 9'd0,   cnt: 16'd1, best: 8'h24};
    vec_a[3] = '{tab: flat(127),    min: 9'd381, cnt: 16'd6, best: 8'h24};
    vec_a[4] = '{tab: diag(9, 0),   min: 9'd0,   cnt: 16'd2, best: 8'h09};

    vec_b[0] = '{tab: flat(3),      min: 9'd12,  cnt: 16'd15, best: 8'hE4};
    vec_b[1] = '{tab: flat(127),    min: 9'd508, cnt: 16'd15, best: 8'hE4};
    vec_b[2] = '{tab: diag(0, 10),  min: 9'd0,   cnt: 16'd1,  best: 8'hE4};
    for (int v = 3; v < 5; v++) begin
      logic [15:0][6:0] t;
      for (int i = 0; i < 16; i++) t[i] = 7'($urandom_range(0, 3));
      vec_b[v] = model4(t);
    end

    // ---------------- instance A ----------------
    load_a(vec_a[0]);
    repeat (3) tick();
    reset_vals_a("a_rst");
    rst_a = 1'b0;
    exp_q.push_back(vec_a[0]);
    finish_a("a_auto", 0);

    repeat (5) tick();
    check("a_done_hold_valid", 32'(valid_a), 1);
    check("a_done_hold_min", 32'(min_a), 9);

    for (int v = 1; v < 5; v++) begin
      load_a(vec_a[v]);
      pulse_start_a();
      check($sformatf("a_v%0d_drop", v), 32'(valid_a), 0);
      exp_q.push_back(vec_a[v]);
      finish_a($sformatf("a_v%0d", v), 0);
    end

    // W/J walk across the first two permutations; a Start mid-search must be ignored.
    load_a(vec_a[0]);
    pulse_start_a();
    check("a_wj0", {w_a, j_a}, {2'd0, 2'd0});
    tick(); check("a_wj1", {w_a, j_a}, {2'd1, 2'd1});
    tick(); check("a_wj2", {w_a, j_a}, {2'd2, 2'd2});
    tick(); check("a_wj_cmp", {w_a, j_a}, {2'd2, 2'd2});
    tick(); check("a_wj4", {w_a, j_a}, {2'd0, 2'd0});
    tick(); check("a_wj5", {w_a, j_a}, {2'd1, 2'd2});
    pulse_start_a();
    exp_q.push_back(vec_a[0]);
    finish_a("a_ign_start", 6);

    // Reset mid-search, then the auto-started search repeats from identity.
    load_a(vec_a[4]);
    pulse_start_a();
    repeat (5) tick();
    rst_a = 1'b1;
    tick();
    reset_vals_a("a_midrst");
    rst_a = 1'b0;
    exp_q.push_back(vec_a[4]);
    finish_a("a_restart", 0);

    // ---------------- instance B ----------------
    check("b_rst_min", 32'(min_b), 511);
    check("b_rst_valid", 32'(valid_b), 0);
    rst_b = 1'b0;
    repeat (130) tick();
    check("b_idle_valid", 32'(valid_b), 0);
    check("b_idle_min", 32'(min_b), 511);

    for (int v = 0; v < 5; v++) begin
      load_b(vec_b[v]);
      pulse_start_b();
      check($sformatf("b_v%0d_drop", v), 32'(valid_b), 0);
      exp_q.push_back(vec_b[v]);
      finish_b($sformatf("b_v%0d", v));
    end

    // RST and Start together in DONE: reset wins and no search follows.
    rst_b = 1'b1; start_b = 1'b1;
    tick();
    rst_b = 1'b0; start_b = 1'b0;
    check("b_rs_valid", 32'(valid_b), 0);
    check("b_rs_cnt", 32'(cnt_b), 0);
    repeat (130) tick();
    check("b_rs_idle_valid", 32'(valid_b), 0);
    check("b_rs_idle_min", 32'(min_b), 511);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
